// File: rtl/ram_copy_engine.sv
// ram_copy_engine: copies len words from src to dst through a two-port word RAM,
// one word per cycle. Port x is the read port and port y is the write port.
// Requests that would overrun the RAM or corrupt their own source are rejected with err.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, src, dst,    request; src/dst/len are sampled with start while IDLE
//   len
//   busy                high while a copy is in flight (RUN and DRAIN)
//   done                1-cycle pulse: copy complete, or an accepted zero-length request
//   err                 1-cycle pulse: request rejected, the RAM is not touched
//   addr_x, data_x,     RAM port x (read only; data_x and we_x are tied low)
//   we_x, q_x
//   addr_y, data_y,     RAM port y (write); data_y is q_x passed straight through
//   we_y
module ram_copy_engine #(
    parameter int unsigned W = 8,
    parameter int unsigned M = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] src,
    input  logic [W-1:0] dst,
    input  logic [W-1:0] len,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] addr_x,
    output logic [W-1:0] data_x,
    output logic         we_x,
    input  logic [W-1:0] q_x,
    output logic [W-1:0] addr_y,
    output logic [W-1:0] data_y,
    output logic         we_y
);

    localparam int unsigned WE    = W + 1;
    localparam logic [WE-1:0] M_LIM = WE'(M);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_dst;
    logic [W-1:0] r_len;
    logic [W-1:0] r_rd_cnt;
    logic [W-1:0] r_addr_x;
    logic [W-1:0] r_addr_y;
    logic         r_we_y;
    logic         r_busy;
    logic         r_done;
    logic         r_err;

    state_t       w_state_nxt;
    logic [W-1:0] w_dst_nxt;
    logic [W-1:0] w_len_nxt;
    logic [W-1:0] w_rd_cnt_nxt;
    logic [W-1:0] w_addr_x_nxt;
    logic [W-1:0] w_addr_y_nxt;
    logic         w_we_y_nxt;
    logic         w_busy_nxt;
    logic         w_done_nxt;
    logic         w_err_nxt;

    logic [WE-1:0] w_src_end;
    logic [WE-1:0] w_dst_end;
    logic [WE-1:0] w_src_p1;
    logic [WE-1:0] w_dst_ext;
    logic          w_bad;

    // Request validation in W+1 bits so a sum can never wrap past the RAM.
    // dst == src+1 is allowed: the read of src+k+1 and the write of dst+k share an edge,
    // and the RAM returns the old word.
    always_comb begin
        w_src_end = {1'b0, src} + {1'b0, len};
        w_dst_end = {1'b0, dst} + {1'b0, len};
        w_src_p1  = {1'b0, src} + WE'(1);
        w_dst_ext = {1'b0, dst};
        w_bad     = (w_src_end > M_LIM) || (w_dst_end > M_LIM) ||
                    ((w_dst_ext > w_src_p1) && (w_dst_ext < w_src_end));
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_dst    <= '0;
            r_len    <= '0;
            r_rd_cnt <= '0;
            r_addr_x <= '0;
            r_addr_y <= '0;
            r_we_y   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dst    <= w_dst_nxt;
            r_len    <= w_len_nxt;
            r_rd_cnt <= w_rd_cnt_nxt;
            r_addr_x <= w_addr_x_nxt;
            r_addr_y <= w_addr_y_nxt;
            r_we_y   <= w_we_y_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next-state and output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_dst_nxt    = r_dst;
        w_len_nxt    = r_len;
        w_rd_cnt_nxt = r_rd_cnt;
        w_addr_x_nxt = r_addr_x;
        w_addr_y_nxt = r_addr_y;
        w_we_y_nxt   = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_bad) begin
                        w_err_nxt = 1'b1;
                    end else if (len == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_dst_nxt    = dst;
                        w_len_nxt    = len;
                        w_rd_cnt_nxt = '0;
                        w_addr_x_nxt = src;
                        w_busy_nxt   = 1'b1;
                        w_state_nxt  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Write address/enable trail the read address by one cycle to meet q_x.
                w_we_y_nxt   = 1'b1;
                w_addr_y_nxt = r_dst + r_rd_cnt;
                if (r_rd_cnt == (r_len - W'(1))) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_rd_cnt_nxt = r_rd_cnt + W'(1);
                    w_addr_x_nxt = r_addr_x + W'(1);
                end
            end
            S_DRAIN: begin
                // Last write commits at this edge.
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign addr_x = r_addr_x;
    assign data_x = '0;
    assign we_x   = 1'b0;
    assign addr_y = r_addr_y;
    assign data_y = q_x;
    assign we_y   = r_we_y;

endmodule

// File: tb/tb_ram_copy_engine.sv
module tb_ram_copy_engine;

    localparam int W  = 8;
    localparam int M  = 32;
    localparam int AW = $clog2(M);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] src, dst, len;
    logic         busy, done, err;
    logic [W-1:0] addr_x, data_x, q_x, addr_y, data_y;
    logic         we_x, we_y;

    ram_copy_engine #(.W(W), .M(M)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .err(err),
        .addr_x(addr_x), .data_x(data_x), .we_x(we_x), .q_x(q_x),
        .addr_y(addr_y), .data_y(data_y), .we_y(we_y)
    );

    always #5 clk = ~clk;

    // Two-port RAM: registered read on x, read-before-write, plus a bench preload port.
    logic [W-1:0]  mem [M];
    logic          tb_we;
    logic [AW-1:0] tb_addr;
    logic [W-1:0]  tb_data;

    always_ff @(posedge clk) begin
        q_x <= mem[addr_x[AW-1:0]];
        if (tb_we)
            mem[tb_addr] <= tb_data;
        else if (we_y)
            mem[addr_y[AW-1:0]] <= data_y;
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] d;
    } wr_t;

    wr_t          exp_q[$];
    logic [W-1:0] ref_mem [M];
    int           n_total = 0;
    int           n_bad   = 0;
    int           n_done  = 0;
    int           n_err   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(input int s, input int d, input int l);
        return (s + l > M) || (d + l > M) || ((d > s + 1) && (d < s + l));
    endfunction

    // Write monitor: every RAM write is popped against the expected-write queue.
    always @(negedge clk) begin
        wr_t e;
        check_val("we_x", 32'(we_x), 32'd0);
        if (rst_n) begin
            if (we_y) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_wr", 32'(addr_y), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_val("wr_addr", 32'(addr_y), 32'(e.a));
                    check_val("wr_data", 32'(data_y), 32'(e.d));
                end
            end
            if (done) n_done++;
            if (err)  n_err++;
            if (done || err) check_val("done_err_excl", 32'(done & err), 32'd0);
        end
    end

    task automatic wr_word(input int a, input int v);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_addr = AW'(a);
        tb_data = W'(v);
        @(negedge clk);
        tb_we   = 1'b0;
        ref_mem[a] = W'(v);
    endtask

    task automatic cmp_ram(input string tag);
        int nm = 0;
        for (int i = 0; i < M; i++)
            if (mem[i] !== ref_mem[i]) nm++;
        check_val(tag, 32'(nm), 32'd0);
    endtask

    // One request: model the outcome, queue expected writes, wait (bounded) for done/err.
    task automatic do_copy(input int s, input int d, input int l, input bit poke);
        bit           bad;
        bit           seen;
        bit           busy_seen;
        int           cyc;
        int           d0, e0;
        logic [W-1:0] snap [M];
        bad = is_bad(s, d, l);
        if (!bad && l > 0) begin
            for (int i = 0; i < M; i++) snap[i] = ref_mem[i];
            for (int k = 0; k < l; k++) begin
                exp_q.push_back('{a: W'(d + k), d: snap[s + k]});
                ref_mem[d + k] = snap[s + k];
            end
        end
        d0 = n_done;
        e0 = n_err;
        @(negedge clk);
        start = 1'b1;
        src   = W'(s);
        dst   = W'(d);
        len   = W'(l);
        cyc = 0;
        seen = 1'b0;
        busy_seen = 1'b0;
        while (!seen && cyc < l + 20) begin
            @(posedge clk);
            #1;
            cyc++;
            start = poke && (cyc == 3);
            if (start) begin
                src = W'(0);
                dst = W'(1);
                len = W'(1);
            end
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
            if (done || err) seen = 1'b1;
        end
        check_val("seen", 32'(seen), 32'd1);
        check_val("latency", 32'(cyc), (bad || l == 0) ? 32'd1 : 32'(l + 2));
        repeat (3) @(negedge clk);
        check_val("n_done", 32'(n_done - d0), bad ? 32'd0 : 32'd1);
        check_val("n_err", 32'(n_err - e0), bad ? 32'd1 : 32'd0);
        if (bad || l == 0) check_val("busy_idle", 32'(busy_seen), 32'd0);
        check_val("q_empty", 32'(exp_q.size()), 32'd0);
        cmp_ram("ram");
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d, l, d0;
        rst_n = 1'b0;
        start = 1'b0;
        src = '0; dst = '0; len = '0;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        #12;
        check_val("rst_busy",   32'(busy),   32'd0);
        check_val("rst_done",   32'(done),   32'd0);
        check_val("rst_err",    32'(err),    32'd0);
        check_val("rst_we_y",   32'(we_y),   32'd0);
        check_val("rst_addr_x", 32'(addr_x), 32'd0);
        check_val("rst_addr_y", 32'(addr_y), 32'd0);
        check_val("rst_we_x",   32'(we_x),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic copy
        for (int i = 0; i < M; i++) wr_word(i, 1);
        for (int i = 0; i < 4; i++) wr_word(i, 'h11 + i);
        do_copy(0, 8, 4, 1'b0);
        check_val("ram8",  32'(mem[8]),  32'h11);
        check_val("ram11", 32'(mem[11]), 32'h14);
        check_val("ram12", 32'(mem[12]), 32'd1);

        // Zero length
        do_copy(3, 20, 0, 1'b0);

        // Hazard: rejected forward overlap, then legal dst == src+1
        for (int i = 4; i < 8; i++) wr_word(i, 'h40 + i);
        do_copy(4, 6, 4, 1'b0);
        do_copy(4, 5, 4, 1'b0);
        check_val("shift5", 32'(mem[5]), 32'h44);
        check_val("shift8", 32'(mem[8]), 32'h47);

        // Range boundaries
        do_copy(M - 2, 0, 3, 1'b0);
        wr_word(M - 1, 'hA5);
        do_copy(M - 3, 0, 3, 1'b0);
        check_val("last_word", 32'(mem[2]), 32'hA5);
        do_copy(0, M - 2, 3, 1'b0);

        // start while busy is ignored
        do_copy(8, 16, 8, 1'b1);

        // Reset mid-copy at rd_cnt == 2: only dst+0 committed
        for (int k = 0; k < 8; k++) exp_q.push_back('{a: W'(16 + k), d: ref_mem[k]});
        ref_mem[16] = ref_mem[0];
        d0 = n_done;
        @(negedge clk);
        start = 1'b1; src = W'(0); dst = W'(16); len = W'(8);
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_we_y", 32'(we_y), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("mid_rst_done", 32'(n_done - d0), 32'd0);
        cmp_ram("mid_rst_ram");

        // Random legal copies against the memmove model
        for (int i = 0; i < M; i++) wr_word(i, $urandom_range(0, 255));
        for (int r = 0; r < 200; r++) begin
            do begin
                s = $urandom_range(0, M - 1);
                d = $urandom_range(0, M - 1);
                l = $urandom_range(1, 8);
            end while (is_bad(s, d, l));
            do_copy(s, d, l, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
